// File: rtl/sw_debounce_4.sv
// Four-channel switch debouncer: two-flop synchronizer, per-bit stability counter,
// registered debounced level plus one-cycle rise/fall/change pulses.
module sw_debounce_4 #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] raw_in,
  output logic [3:0] sw_out,
  output logic [3:0] rise,
  output logic [3:0] fall,
  output logic       change_strobe
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    r_sw;
  logic [3:0]    r_rise;
  logic [3:0]    r_fall;
  logic          r_chg;

  logic [3:0]    w_diff;
  logic [3:0]    w_load;

  always_comb begin
    w_diff = r_sync2 ^ r_sw;
    w_load = '0;
    for (int i = 0; i < 4; i++) begin
      w_load[i] = w_diff[i] && (r_cnt[i] == TERM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Counter only advances while the synchronized level disagrees with the output;
  // a qualifying edge or any agreement returns it to zero, so it never passes TERM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!w_diff[i] || w_load[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw   <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_chg  <= 1'b0;
    end else begin
      r_sw   <= r_sw ^ w_load;
      r_rise <= w_load & r_sync2;
      r_fall <= w_load & ~r_sync2;
      r_chg  <= |w_load;
    end
  end

  assign sw_out        = r_sw;
  assign rise          = r_rise;
  assign fall          = r_fall;
  assign change_strobe = r_chg;

endmodule

// File: tb/tb_sw_debounce_4.sv
// Directed bench for sw_debounce_4: table of per-cycle vectors for the default
// STABLE_CYCLES=4 instance plus hand sequences for pulses, bounce, reset and STABLE_CYCLES=1.
module tb_sw_debounce_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] raw_in;
  logic [3:0] sw_out, rise, fall;
  logic       change_strobe;

  logic [3:0] raw_in1;
  logic [3:0] sw_out1, rise1, fall1;
  logic       change_strobe1;

  int n_checks = 0;
  int n_errors = 0;

  sw_debounce_4 #(.STABLE_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
    .sw_out(sw_out), .rise(rise), .fall(fall), .change_strobe(change_strobe)
  );

  sw_debounce_4 #(.STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in1),
    .sw_out(sw_out1), .rise(rise1), .fall(fall1), .change_strobe(change_strobe1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] raw;
    logic [3:0] sw;
    logic [3:0] ri;
    logic [3:0] fa;
    logic       chg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] raw, logic [3:0] sw, logic [3:0] ri,
                              logic [3:0] fa, logic chg);
    vec_t v;
    v.raw = raw; v.sw = sw; v.ri = ri; v.fa = fa; v.chg = chg;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [3:0] a_sw, a_ri, a_fa, input logic a_chg,
                     input logic [3:0] e_sw, e_ri, e_fa, input logic e_chg);
    n_checks++;
    if ({a_sw, a_ri, a_fa, a_chg} !== {e_sw, e_ri, e_fa, e_chg}) begin
      n_errors++;
      $display("FAIL %s: got sw=%b rise=%b fall=%b chg=%b, expected sw=%b rise=%b fall=%b chg=%b",
               tag, a_sw, a_ri, a_fa, a_chg, e_sw, e_ri, e_fa, e_chg);
    end
  endtask

  task automatic step(input logic [3:0] raw, input logic [3:0] e_sw, e_ri, e_fa,
                      input logic e_chg, input string tag);
    raw_in = raw;
    @(posedge clk);
    #1;
    chk(tag, sw_out, rise, fall, change_strobe, e_sw, e_ri, e_fa, e_chg);
  endtask

  task automatic step1(input logic [3:0] raw, input logic [3:0] e_sw, e_ri, e_fa,
                       input logic e_chg, input string tag);
    raw_in1 = raw;
    @(posedge clk);
    #1;
    chk(tag, sw_out1, rise1, fall1, change_strobe1, e_sw, e_ri, e_fa, e_chg);
  endtask

  initial begin
    logic [3:0] r, esw, eri, efa;
    logic       ech;

    // Single-bit rise then fall, 5-edge latency each way.
    for (int c = 0; c < 5; c++) vecs.push_back(mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0));
    for (int c = 0; c < 5; c++) vecs.push_back(mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    // All four bits together: one shared strobe.
    for (int c = 0; c < 5; c++) vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0));
    for (int c = 0; c < 5; c++) vecs.push_back(mk(4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0));

    raw_in  = 4'b0000;
    raw_in1 = 4'b0000;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset4", sw_out, rise, fall, change_strobe, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("reset1", sw_out1, rise1, fall1, change_strobe1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, $sformatf("idle c%0d", c));

    foreach (vecs[i]) begin
      step(vecs[i].raw, vecs[i].sw, vecs[i].ri, vecs[i].fa, vecs[i].chg, $sformatf("vec%0d", i));
    end

    // 3-clock glitch on bit 2: never qualifies.
    for (int c = 0; c < 11; c++) begin
      r = (c < 3) ? 4'b0100 : 4'b0000;
      step(r, 4'b0000, 4'b0000, 4'b0000, 1'b0, $sformatf("pulse3 c%0d", c));
    end

    // 4-clock pulse qualifies, then falls 4 edges after its own update.
    for (int c = 0; c < 12; c++) begin
      r   = (c < 4) ? 4'b0100 : 4'b0000;
      esw = (c >= 5 && c <= 8) ? 4'b0100 : 4'b0000;
      eri = (c == 5) ? 4'b0100 : 4'b0000;
      efa = (c == 9) ? 4'b0100 : 4'b0000;
      ech = (c == 5) || (c == 9);
      step(r, esw, eri, efa, ech, $sformatf("pulse4 c%0d", c));
    end

    // Bit 1 bounces for 10 clocks, settles high at c=10, updates once at c=15.
    for (int c = 0; c < 17; c++) begin
      r   = (c < 10) ? ((c % 2 == 0) ? 4'b0010 : 4'b0000) : 4'b0010;
      esw = (c >= 15) ? 4'b0010 : 4'b0000;
      eri = (c == 15) ? 4'b0010 : 4'b0000;
      ech = (c == 15);
      step(r, esw, eri, 4'b0000, ech, $sformatf("bounce c%0d", c));
    end

    // Bit 0 starts qualifying; counter reaches 2 after c3, then reset strikes.
    for (int c = 0; c < 4; c++) step(4'b0011, 4'b0010, 4'b0000, 4'b0000, 1'b0, $sformatf("prerst c%0d", c));
    #2 rst_n = 1'b0;
    #1 chk("rst_async_a", sw_out, rise, fall, change_strobe, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    #3 chk("rst_async_b", sw_out, rise, fall, change_strobe, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      esw = (c >= 5) ? 4'b0011 : 4'b0000;
      eri = (c == 5) ? 4'b0011 : 4'b0000;
      ech = (c == 5);
      step(4'b0011, esw, eri, 4'b0000, ech, $sformatf("postrst c%0d", c));
    end

    // STABLE_CYCLES=1: bit 3 toggles every clock, output follows 2 edges later.
    for (int c = 0; c < 12; c++) begin
      r   = (c % 2 == 0) ? 4'b1000 : 4'b0000;
      esw = (c >= 2 && c % 2 == 0) ? 4'b1000 : 4'b0000;
      eri = (c >= 2 && c % 2 == 0) ? 4'b1000 : 4'b0000;
      efa = (c >= 3 && c % 2 == 1) ? 4'b1000 : 4'b0000;
      ech = (c >= 2);
      step1(r, esw, eri, efa, ech, $sformatf("sc1 c%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
